ddr_port_arbiter: RTL

- Shares the single-ported DDR interface (ddr_addr/read/write/wdata/rdata/resp) between the instruction-fetch requester (read-only) and the data requester (read/write).
- Captures the winning request, drives the DDR port from internal registers, and waits for the one-cycle ddr_resp pulse.
- Returns registered read data and a one-cycle resp to the owning requester.
- Round-robin arbitration on conflict; watchdog timeout so a hung memory cannot deadlock the core.

---
 rtl/ddr_port_arbiter_if.sv | 40 ++++
 rtl/ddr_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter_if.sv
// Requester and memory-side signals of the DDR port arbiter.
// master = arbiter view, slave = requester/memory environment view.
interface ddr_port_arbiter_if;
  logic [31:0] i_addr;
  logic        i_read;
  logic [31:0] i_rdata;
  logic        i_resp;

  logic [31:0] d_addr;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;

  logic [31:0] ddr_addr;
  logic        ddr_read;
  logic        ddr_write;
  logic [31:0] ddr_wdata;
  logic [31:0] ddr_rdata;
  logic        ddr_resp;

  modport master (
    input  i_addr, i_read,
    output i_rdata, i_resp,
    input  d_addr, d_read, d_write, d_wdata,
    output d_rdata, d_resp,
    output ddr_addr, ddr_read, ddr_write, ddr_wdata,
    input  ddr_rdata, ddr_resp
  );

  modport slave (
    output i_addr, i_read,
    input  i_rdata, i_resp,
    output d_addr, d_read, d_write, d_wdata,
    input  d_rdata, d_resp,
    input  ddr_addr, ddr_read, ddr_write, ddr_wdata,
    output ddr_rdata, ddr_resp
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR port between the instruction-fetch and data requesters,
// with round-robin arbitration on conflict and a BUSY watchdog.
module ddr_port_arbiter #(
  parameter logic        D_FIRST = 1'b1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  ddr_port_arbiter_if.master  bus,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_n;
  logic [31:0]   addr_q, addr_n;
  logic          rd_q, rd_n;
  logic          wr_q, wr_n;
  logic [31:0]   wdata_q, wdata_n;
  logic          own_d, own_d_n;
  logic          last_d, last_d_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   i_rdata_q, i_rdata_n;
  logic [31:0]   d_rdata_q, d_rdata_n;
  logic          i_resp_q, i_resp_n;
  logic          d_resp_q, d_resp_n;
  logic          terr_q, terr_n;

  logic i_pend, d_pend, grant_d;

  assign i_pend  = bus.i_read;
  assign d_pend  = bus.d_read | bus.d_write;
  assign grant_d = d_pend & (~i_pend | ~last_d);

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    rd_n      = rd_q;
    wr_n      = wr_q;
    wdata_n   = wdata_q;
    own_d_n   = own_d;
    last_d_n  = last_d;
    cnt_n     = cnt;
    i_rdata_n = i_rdata_q;
    d_rdata_n = d_rdata_q;
    i_resp_n  = 1'b0;
    d_resp_n  = 1'b0;
    terr_n    = terr_q;

    case (state)
      IDLE: begin
        if (i_pend | d_pend) begin
          state_n  = BUSY;
          own_d_n  = grant_d;
          last_d_n = grant_d;
          cnt_n    = '0;
          if (grant_d) begin
            // a simultaneous read+write request is served as a write
            addr_n  = bus.d_addr;
            wr_n    = bus.d_write;
            rd_n    = ~bus.d_write;
            wdata_n = bus.d_wdata;
          end else begin
            addr_n = bus.i_addr;
            rd_n   = 1'b1;
            wr_n   = 1'b0;
          end
        end
      end

      BUSY: begin
        if (bus.ddr_resp) begin
          state_n  = RESP;
          rd_n     = 1'b0;
          wr_n     = 1'b0;
          i_resp_n = ~own_d;
          d_resp_n = own_d;
          if (rd_q) begin
            if (own_d) d_rdata_n = bus.ddr_rdata;
            else       i_rdata_n = bus.ddr_rdata;
          end
        end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
          // this edge completes the TIMEOUT-th BUSY cycle: abort
          state_n  = RESP;
          cnt_n    = cnt + 1'b1;
          rd_n     = 1'b0;
          wr_n     = 1'b0;
          terr_n   = 1'b1;
          i_resp_n = ~own_d;
          d_resp_n = own_d;
          if (own_d) d_rdata_n = '0;
          else       i_rdata_n = '0;
        end else if (TIMEOUT > 0) begin
          cnt_n = cnt + 1'b1;
        end
      end

      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      own_d     <= 1'b0;
      last_d    <= ~D_FIRST;
      cnt       <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      rd_q      <= rd_n;
      wr_q      <= wr_n;
      wdata_q   <= wdata_n;
      own_d     <= own_d_n;
      last_d    <= last_d_n;
      cnt       <= cnt_n;
      i_rdata_q <= i_rdata_n;
      d_rdata_q <= d_rdata_n;
      i_resp_q  <= i_resp_n;
      d_resp_q  <= d_resp_n;
      terr_q    <= terr_n;
    end
  end

  assign bus.ddr_addr  = addr_q;
  assign bus.ddr_read  = rd_q;
  assign bus.ddr_write = wr_q;
  assign bus.ddr_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_resp    = i_resp_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_resp    = d_resp_q;
  assign busy          = (state != IDLE);
  assign timeout_err   = terr_q;

endmodule
